reservation_station: RTL

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/tomasula_types.sv | 42 ++++
 rtl/rs_select.sv | 44 ++++
 rtl/reservation_station.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/tomasula_types.sv
// rtl/tomasula_types.sv - shared control word, station entry, CDB types and the CDB capture helper
package tomasula_types;

  localparam int MAX_TAG_W = 8;

  typedef struct packed {
    logic [3:0] op;
    logic [3:0] fn;
  } ctl_word;

  typedef struct packed {
    logic                 rdy;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          val;
  } rs_src_t;

  typedef struct packed {
    logic                 busy;
    ctl_word              ctl;
    logic [MAX_TAG_W-1:0] dest;
    rs_src_t              src1;
    rs_src_t              src2;
  } rs_entry_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    logic [31:0]          val;
  } cdb_t;

  // A waiting operand snoops the broadcast; an already-ready one is left alone.
  function automatic rs_src_t capture_src(input rs_src_t s, input cdb_t c);
    rs_src_t r;
    r = s;
    if (!s.rdy && c.valid && (s.tag == c.tag)) begin
      r.rdy = 1'b1;
      r.val = c.val;
    end
    return r;
  endfunction

endpackage

// File: rtl/rs_select.sv
// rtl/rs_select.sv - dispatch pick: lowest eligible index, or oldest eligible with RS_OLDEST_FIRST_EN
module rs_select #(
  parameter int  DEPTH = 4,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]             elig,
`ifdef RS_OLDEST_FIRST_EN
  input  logic [DEPTH-1:0][IDX_W-1:0]  age,
`endif
  output logic [DEPTH-1:0]             grant,
  output logic [IDX_W-1:0]             idx,
  output logic                         any
);

`ifdef RS_OLDEST_FIRST_EN
  logic [IDX_W-1:0] best_age;
  logic             found;

  // Ages are unique ranks among busy entries, so the strict compare never ties.
  always_comb begin
    idx      = '0;
    best_age = '0;
    found    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (elig[i] && (!found || age[i] > best_age)) begin
        found    = 1'b1;
        best_age = age[i];
        idx      = IDX_W'(i);
      end
    end
  end
`else
  always_comb begin
    idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (elig[i]) idx = IDX_W'(i);
    end
  end
`endif

  assign any   = |elig;
  assign grant = any ? (DEPTH'(1) << idx) : '0;

endmodule

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - Tomasulo reservation station with CDB snooping; RS_OLDEST_FIRST_EN selects age-ordered dispatch
module reservation_station
  import tomasula_types::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  ctl_word          control_i,
  input  logic [TAG_W-1:0] rob_tag_i,
  input  logic             src1_rdy_i,
  input  logic             src2_rdy_i,
  input  logic [TAG_W-1:0] src1_tag_i,
  input  logic [TAG_W-1:0] src2_tag_i,
  input  logic [31:0]      src1_val_i,
  input  logic [31:0]      src2_val_i,
  input  logic             cdb_valid_i,
  input  logic [TAG_W-1:0] cdb_tag_i,
  input  logic [31:0]      cdb_val_i,
  output logic             empty_o,
  output logic             exe_valid_o,
  input  logic             exe_ready_i,
  output ctl_word          exe_ctl_o,
  output logic [31:0]      exe_a_o,
  output logic [31:0]      exe_b_o,
  output logic [TAG_W-1:0] exe_tag_o,
  input  logic             flush_i
);

  localparam int IDX_W = $clog2(DEPTH);

  rs_entry_t            ent_q [DEPTH];
  logic [DEPTH-1:0]     busy;
  logic [DEPTH-1:0]     elig;
  logic [DEPTH-1:0]     arb_grant;
  logic [DEPTH-1:0]     clr_mask;
  logic [IDX_W-1:0]     arb_idx;
  logic [IDX_W-1:0]     sel_idx;
  logic [IDX_W-1:0]     load_idx;
  logic [IDX_W-1:0]     lock_idx_q;
  logic                 arb_any;
  logic                 lock_q;
  logic                 do_load;
  logic                 dispatch;
  logic [MAX_TAG_W-1:0] sel_dest_unused;
  cdb_t                 cdb;
  rs_entry_t            new_ent;

  always_comb begin
    busy = '0;
    elig = '0;
    for (int i = 0; i < DEPTH; i++) begin
      busy[i] = ent_q[i].busy;
      elig[i] = ent_q[i].busy & ent_q[i].src1.rdy & ent_q[i].src2.rdy;
    end
  end

  always_comb begin
    load_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i]) load_idx = IDX_W'(i);
    end
  end

  assign empty_o  = |(~busy);
  assign do_load  = load_i & empty_o;
  assign cdb      = '{valid: cdb_valid_i, tag: MAX_TAG_W'(cdb_tag_i), val: cdb_val_i};

  always_comb begin
    new_ent           = '0;
    new_ent.busy      = 1'b1;
    new_ent.ctl       = control_i;
    new_ent.dest      = MAX_TAG_W'(rob_tag_i);
    new_ent.src1.rdy  = src1_rdy_i;
    new_ent.src1.tag  = MAX_TAG_W'(src1_tag_i);
    new_ent.src1.val  = src1_val_i;
    new_ent.src2.rdy  = src2_rdy_i;
    new_ent.src2.tag  = MAX_TAG_W'(src2_tag_i);
    new_ent.src2.val  = src2_val_i;
    new_ent.src1      = capture_src(new_ent.src1, cdb);
    new_ent.src2      = capture_src(new_ent.src2, cdb);
  end

`ifdef RS_OLDEST_FIRST_EN
  // Rank among busy entries: 0 is youngest; a departure closes the gap above it.
  logic [DEPTH-1:0][IDX_W-1:0] age_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      age_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (do_load && load_idx == IDX_W'(i)) begin
          age_q[i] <= '0;
        end else if (busy[i]) begin
          age_q[i] <= IDX_W'(int'(age_q[i]) + int'(do_load)
                      - int'(dispatch && (age_q[i] > age_q[sel_idx])));
        end
      end
    end
  end
`endif

  rs_select #(.DEPTH(DEPTH)) u_select (
    .elig  (elig),
`ifdef RS_OLDEST_FIRST_EN
    .age   (age_q),
`endif
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // A stalled offer is pinned so a newly eligible entry cannot displace it.
  assign sel_idx     = lock_q ? lock_idx_q : arb_idx;
  assign clr_mask    = lock_q ? (DEPTH'(1) << lock_idx_q) : arb_grant;
  assign exe_valid_o = lock_q | arb_any;
  assign dispatch    = exe_valid_o & exe_ready_i;

  assign sel_dest_unused = ent_q[sel_idx].dest;
  assign exe_ctl_o  = exe_valid_o ? ent_q[sel_idx].ctl      : '0;
  assign exe_a_o    = exe_valid_o ? ent_q[sel_idx].src1.val : '0;
  assign exe_b_o    = exe_valid_o ? ent_q[sel_idx].src2.val : '0;
  assign exe_tag_o  = exe_valid_o ? sel_dest_unused[TAG_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i]) begin
          ent_q[i].src1 <= capture_src(ent_q[i].src1, cdb);
          ent_q[i].src2 <= capture_src(ent_q[i].src2, cdb);
        end
        if (dispatch && clr_mask[i]) ent_q[i].busy <= 1'b0;
        if (do_load && load_idx == IDX_W'(i)) ent_q[i] <= new_ent;
      end
      lock_q     <= exe_valid_o & ~exe_ready_i;
      lock_idx_q <= sel_idx;
    end
  end

endmodule
